// File: rtl/ex_mem_buffer_if.sv
// rtl/ex_mem_buffer_if.sv - Execute/Memory boundary bundle: upstream beat, head payload, forwarding
interface ex_mem_buffer_if #(
    parameter int XLEN = 32
);
    logic            flush;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ex_store_data;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [2:0]      ex_funct3;

    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_result;
    logic [XLEN-1:0] mem_store_data;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic            mem_mem_read;
    logic            mem_mem_write;
    logic [2:0]      mem_funct3;

    logic [4:0]      fwd_rs1;
    logic [4:0]      fwd_rs2;
    logic            fwd_rs1_hit;
    logic            fwd_rs2_hit;
    logic [XLEN-1:0] fwd_rs1_data;
    logic [XLEN-1:0] fwd_rs2_data;
    logic            fwd_rs1_load;
    logic            fwd_rs2_load;

    modport master (
        output flush,
        output ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_funct3,
        input  ex_ready,
        input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_funct3,
        output mem_ready,
        output fwd_rs1, fwd_rs2,
        input  fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data,
               fwd_rs1_load, fwd_rs2_load
    );

    modport slave (
        input  flush,
        input  ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_funct3,
        output ex_ready,
        output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_funct3,
        input  mem_ready,
        input  fwd_rs1, fwd_rs2,
        output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data,
               fwd_rs1_load, fwd_rs2_load
    );
endinterface

// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - two-entry skid buffer between Execute and Memory with operand forwarding
module ex_mem_buffer #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_mem_buffer_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
    } entry_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0] state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    entry_t     ex_entry;
    logic       head_valid, skid_valid;
    logic       beat_in, beat_out;

    // Valid bits are decoded from registered state only, so ex_ready never sees mem_ready.
    assign head_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign skid_valid = (state_q == ST_TWO);

    assign ex_entry.result     = bus.ex_result;
    assign ex_entry.store_data = bus.ex_store_data;
    assign ex_entry.rd         = bus.ex_rd;
    assign ex_entry.reg_write  = bus.ex_reg_write;
    assign ex_entry.mem_read   = bus.ex_mem_read;
    assign ex_entry.mem_write  = bus.ex_mem_write;
    assign ex_entry.funct3     = bus.ex_funct3;

    assign bus.ex_ready = !skid_valid;
    assign beat_in      = bus.ex_valid && !skid_valid;
    assign beat_out     = head_valid && bus.mem_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (beat_in) begin
                    head_d  = ex_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (beat_in && beat_out) begin
                    head_d = ex_entry;
                end else if (beat_in) begin
                    skid_d  = ex_entry;
                    state_d = ST_TWO;
                end else if (beat_out) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (beat_out) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Redirect kills everything; payload may still load but is never observed.
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.mem_valid      = head_valid;
    assign bus.mem_result     = head_q.result;
    assign bus.mem_store_data = head_q.store_data;
    assign bus.mem_rd         = head_q.rd;
    assign bus.mem_reg_write  = head_q.reg_write;
    assign bus.mem_mem_read   = head_q.mem_read;
    assign bus.mem_mem_write  = head_q.mem_write;
    assign bus.mem_funct3     = head_q.funct3;

    function automatic logic produces(input logic v, input entry_t e, input logic [4:0] rs);
        return v && e.reg_write && (e.rd != 5'd0) && (e.rd == rs);
    endfunction

    // The skid holds the younger instruction, so it wins over the head.
    always_comb begin
        bus.fwd_rs1_hit  = 1'b0;
        bus.fwd_rs1_data = '0;
        bus.fwd_rs1_load = 1'b0;
        if (produces(skid_valid, skid_q, bus.fwd_rs1)) begin
            bus.fwd_rs1_hit  = 1'b1;
            bus.fwd_rs1_data = skid_q.result;
            bus.fwd_rs1_load = skid_q.mem_read;
        end else if (produces(head_valid, head_q, bus.fwd_rs1)) begin
            bus.fwd_rs1_hit  = 1'b1;
            bus.fwd_rs1_data = head_q.result;
            bus.fwd_rs1_load = head_q.mem_read;
        end
    end

    always_comb begin
        bus.fwd_rs2_hit  = 1'b0;
        bus.fwd_rs2_data = '0;
        bus.fwd_rs2_load = 1'b0;
        if (produces(skid_valid, skid_q, bus.fwd_rs2)) begin
            bus.fwd_rs2_hit  = 1'b1;
            bus.fwd_rs2_data = skid_q.result;
            bus.fwd_rs2_load = skid_q.mem_read;
        end else if (produces(head_valid, head_q, bus.fwd_rs2)) begin
            bus.fwd_rs2_hit  = 1'b1;
            bus.fwd_rs2_data = head_q.result;
            bus.fwd_rs2_load = head_q.mem_read;
        end
    end
endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - scoreboard bench for ex_mem_buffer
module tb_ex_mem_buffer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [74:0] sb[$];

    ex_mem_buffer_if #(.XLEN(32)) ifc ();

    ex_mem_buffer #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] pk(input logic [31:0] res, input logic [31:0] sd,
                                       input logic [4:0] rd, input logic rw, input logic mr,
                                       input logic mw, input logic [2:0] f3);
        return {res, sd, rd, rw, mr, mw, f3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat; expected payload is queued when the handshake is seen before the edge.
    task automatic send(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        bit done;
        done = 0;
        ifc.ex_valid      = 1'b1;
        ifc.ex_result     = res;
        ifc.ex_store_data = sd;
        ifc.ex_rd         = rd;
        ifc.ex_reg_write  = rw;
        ifc.ex_mem_read   = mr;
        ifc.ex_mem_write  = mw;
        ifc.ex_funct3     = f3;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ifc.ex_ready === 1'b1) begin
                sb.push_back(pk(res, sd, rd, rw, mr, mw, f3));
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        ifc.ex_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got ex_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    // Monitor: every head handshake must match the oldest queued beat.
    always @(negedge clk) begin
        logic [74:0] act;
        logic [74:0] exp;
        if (rst_n === 1'b1 && ifc.mem_valid === 1'b1 && ifc.mem_ready === 1'b1) begin
            act = {ifc.mem_result, ifc.mem_store_data, ifc.mem_rd, ifc.mem_reg_write,
                   ifc.mem_mem_read, ifc.mem_mem_write, ifc.mem_funct3};
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL mon_unexpected: got beat %h expected none", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL mon_payload: got %h expected %h", act, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifc.flush = 1'b0;
        ifc.ex_valid = 1'b0;
        ifc.ex_result = '0;
        ifc.ex_store_data = '0;
        ifc.ex_rd = '0;
        ifc.ex_reg_write = 1'b0;
        ifc.ex_mem_read = 1'b0;
        ifc.ex_mem_write = 1'b0;
        ifc.ex_funct3 = '0;
        ifc.mem_ready = 1'b0;
        ifc.fwd_rs1 = '0;
        ifc.fwd_rs2 = '0;

        // Reset state
        #12;
        check("rst_ex_ready", {31'd0, ifc.ex_ready}, 32'd1);
        check("rst_mem_valid", {31'd0, ifc.mem_valid}, 32'd0);
        check("rst_mem_result", ifc.mem_result, 32'd0);
        check("rst_fwd_hit", {31'd0, ifc.fwd_rs1_hit}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single beat
        ifc.mem_ready = 1'b1;
        send(32'h0000_00A5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        check("single_valid", {31'd0, ifc.mem_valid}, 32'd1);
        check("single_result", ifc.mem_result, 32'h0000_00A5);
        check("single_rd", {27'd0, ifc.mem_rd}, 32'd3);
        step();
        check("single_drained", {31'd0, ifc.mem_valid}, 32'd0);

        // Full-rate stream with assorted payload
        send(32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 1'b0, 1'b0, 1'b1, 3'd2);
        send(32'h8000_0000, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 3'd4);
        send(32'h0000_0FFF, 32'hFFFF_FFFF, 5'd17, 1'b1, 1'b0, 1'b0, 3'd5);
        repeat (3) step();

        // Back-pressure: third beat must wait upstream
        ifc.mem_ready = 1'b0;
        fork
            begin
                send(32'h1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
                send(32'h2, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
                send(32'h3, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
            end
            begin
                repeat (3) step();
                check("bp_ex_ready", {31'd0, ifc.ex_ready}, 32'd0);
                check("bp_head", ifc.mem_result, 32'h1);
                check("bp_head_valid", {31'd0, ifc.mem_valid}, 32'd1);
                ifc.mem_ready = 1'b1;
            end
        join
        repeat (3) step();
        check("bp_drained", {31'd0, ifc.mem_valid}, 32'd0);

        // Flush while full, with a beat offered
        ifc.mem_ready = 1'b0;
        send(32'hA, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0);
        send(32'hB, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0);
        ifc.ex_valid = 1'b1;
        ifc.ex_result = 32'hC;
        ifc.flush = 1'b1;
        step();
        ifc.flush = 1'b0;
        ifc.ex_valid = 1'b0;
        sb.delete();
        check("flush_mem_valid", {31'd0, ifc.mem_valid}, 32'd0);
        check("flush_ex_ready", {31'd0, ifc.ex_ready}, 32'd1);
        ifc.mem_ready = 1'b1;
        step();
        check("flush_no_ghost", {31'd0, ifc.mem_valid}, 32'd0);

        // Forward priority
        ifc.mem_ready = 1'b0;
        ifc.fwd_rs1 = 5'd5;
        send(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
        check("fwd_head_hit", {31'd0, ifc.fwd_rs1_hit}, 32'd1);
        check("fwd_head_data", ifc.fwd_rs1_data, 32'h10);
        send(32'h20, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
        check("fwd_skid_hit", {31'd0, ifc.fwd_rs1_hit}, 32'd1);
        check("fwd_skid_data", ifc.fwd_rs1_data, 32'h20);
        check("fwd_skid_load", {31'd0, ifc.fwd_rs1_load}, 32'd0);
        ifc.mem_ready = 1'b1;
        repeat (3) step();

        // Forward exclusions
        ifc.mem_ready = 1'b0;
        send(32'hFF, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        send(32'h33, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 3'd2);
        ifc.fwd_rs1 = 5'd0;
        ifc.fwd_rs2 = 5'd9;
        #1;
        check("excl_rd0_hit", {31'd0, ifc.fwd_rs1_hit}, 32'd0);
        check("excl_rd0_data", ifc.fwd_rs1_data, 32'd0);
        check("excl_nowr_hit", {31'd0, ifc.fwd_rs2_hit}, 32'd0);
        check("excl_nowr_data", ifc.fwd_rs2_data, 32'd0);
        ifc.fwd_rs2 = 5'd0;
        #1;
        check("excl_rs0_hit", {31'd0, ifc.fwd_rs2_hit}, 32'd0);
        ifc.mem_ready = 1'b1;
        repeat (3) step();

        // Load hazard
        ifc.mem_ready = 1'b0;
        send(32'h44, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'd2);
        ifc.fwd_rs1 = 5'd7;
        ifc.fwd_rs2 = 5'd7;
        #1;
        check("load_hit", {31'd0, ifc.fwd_rs1_hit}, 32'd1);
        check("load_flag", {31'd0, ifc.fwd_rs1_load}, 32'd1);
        check("load_data", ifc.fwd_rs1_data, 32'h44);
        check("load_rs2_flag", {31'd0, ifc.fwd_rs2_load}, 32'd1);
        ifc.mem_ready = 1'b1;
        repeat (2) step();
        check("load_gone", {31'd0, ifc.fwd_rs1_hit}, 32'd0);

        // Async reset between edges while full
        ifc.mem_ready = 1'b0;
        send(32'h51, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
        send(32'h52, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
        check("pre_rst_ex_ready", {31'd0, ifc.ex_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", {31'd0, ifc.mem_valid}, 32'd0);
        check("arst_ex_ready", {31'd0, ifc.ex_ready}, 32'd1);
        check("arst_mem_result", ifc.mem_result, 32'd0);
        sb.delete();
        #4;
        rst_n = 1'b1;
        step();

        // Post-reset beat still flows, and nothing is left outstanding
        ifc.mem_ready = 1'b1;
        send(32'h0000_0077, 32'h0000_0088, 5'd12, 1'b1, 1'b0, 1'b1, 3'd1);
        repeat (3) step();
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
